itype_exec_ctrl: RTL

- Multi-cycle sequencer for I-type ALU instructions (opcode 7'b0010011).
- Accepts one 32-bit instruction over a valid/ready handshake and decodes rs1, rd, func3 and imm.
- Reads rs1 from the external register file, computes the result with the internal ALU datapath, writes rd back, then returns to idle.
- Sits between the fetch stage and the register file and replaces the free-running single-op ALU path with a sequenced, full-opcode execute unit.

---
 rtl/itype_exec_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/itype_exec_ctrl.sv
// Sequenced execute unit for RISC-V I-type ALU ops.
// Accept -> read rs1 -> compute -> write back rd.
module itype_exec_ctrl #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [RA_W-1:0] rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            done,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_WB, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:7]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rf_we_q, rf_we_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;

  logic            legal;
  logic [2:0]      f3_in;
  logic [6:0]      f7_in;
  logic [XLEN-1:0] imm;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] alu_res;

  assign instr_ready = (state_q == S_IDLE);
  assign rf_raddr    = instr_q[19:15];
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign busy        = busy_q;

  // Legality of the word offered on the handshake
  always_comb begin
    f3_in = instr[14:12];
    f7_in = instr[31:25];
    legal = (instr[6:0] == 7'b0010011);
    if (f3_in == 3'b001 && f7_in != 7'b0)
      legal = 1'b0;
    if (f3_in == 3'b101 && f7_in != 7'b0
        && f7_in != 7'b0100000)
      legal = 1'b0;
  end

  // ALU on the latched instruction and operand
  always_comb begin
    imm     = {{(XLEN-12){instr_q[31]}},
               instr_q[31:20]};
    shamt   = instr_q[24:20];
    sra_res = $signed(a_q) >>> shamt;
    alu_res = '0;
    case (instr_q[14:12])
      3'b000: alu_res = a_q + imm;
      3'b010: alu_res =
        XLEN'($signed(a_q) < $signed(imm));
      3'b011: alu_res = XLEN'(a_q < imm);
      3'b100: alu_res = a_q ^ imm;
      3'b110: alu_res = a_q | imm;
      3'b111: alu_res = a_q & imm;
      3'b001: alu_res = a_q << shamt;
      3'b101: alu_res = instr_q[30] ? sra_res
                                    : a_q >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (instr_valid)
                state_d = legal ? S_READ : S_ERR;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates per state
  always_comb begin
    instr_d    = instr_q;
    a_d        = a_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (state_q == S_IDLE && instr_valid)
      instr_d = instr[31:7];
    if (state_q == S_READ)
      a_d = rf_rdata;
    if (state_q == S_EXEC) begin
      rf_wdata_d = alu_res;
      rf_waddr_d = instr_q[11:7];
    end
  end

  // Registered outputs follow the state being entered
  always_comb begin
    rf_we_d   = (state_d == S_WB)
                && (instr_q[11:7] != 5'd0);
    done_d    = (state_d == S_WB);
    illegal_d = (state_d == S_ERR);
    busy_d    = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      a_q        <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_we_q    <= rf_we_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
    end
  end

endmodule
